// File: rtl/shiftreg_pkg.sv
// ---------------------------------------------------------------------------
// shiftreg_pkg: shared FSM encodings and default sizing for the SIPO receiver.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package shiftreg_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sipo_out_buf.sv
// ---------------------------------------------------------------------------
// sipo_out_buf: one-deep ready/valid holding register; pulses drop when full.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sipo_out_buf
    import shiftreg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             drop
);

    // A word consumed in the same cycle frees the slot for the incoming one.
    logic slot_free;
    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            drop      <= 1'b0;
        end else begin
            drop <= 1'b0;
            if (load) begin
                if (slot_free) begin
                    out       <= data;
                    out_valid <= 1'b1;
                end else begin
                    drop <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/shiftreg_sipo_rx.sv
// ---------------------------------------------------------------------------
// shiftreg_sipo_rx: serial-in/parallel-out receiver feeding a 1-deep buffer.
// Optional even-parity bit per frame: define SHIFTREG_SIPO_PARITY_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shiftreg_sipo_rx
    import shiftreg_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             start,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             parity_err
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt, shifted, word;
    logic             commit;

    assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], sin} : {sin, shreg[WIDTH-1:1]};

`ifdef SHIFTREG_SIPO_PARITY_EN
    logic perr_nxt;
    // The data is already fully shifted in while the parity bit is examined.
    assign word = shreg;
`else
    assign word = shifted;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        commit    = 1'b0;
`ifdef SHIFTREG_SIPO_PARITY_EN
        perr_nxt  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (start && sin_valid) begin
                    state_nxt = ST_SHIFT;
                    cnt_nxt   = CW'(1);
                    shreg_nxt = shifted;
                end
            end
            ST_SHIFT: begin
                if (sin_valid) begin
                    shreg_nxt = shifted;
                    if (cnt == LAST) begin
                        cnt_nxt = '0;
`ifdef SHIFTREG_SIPO_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_IDLE;
                        commit    = 1'b1;
`endif
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
`ifdef SHIFTREG_SIPO_PARITY_EN
            ST_PARITY: begin
                if (sin_valid) begin
                    state_nxt = ST_IDLE;
                    if (^{shreg, sin}) begin
                        perr_nxt = 1'b1;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef SHIFTREG_SIPO_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= perr_nxt;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    sipo_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (commit),
        .data      (word),
        .out_ready (out_ready),
        .out       (out),
        .out_valid (out_valid),
        .drop      (overrun)
    );

endmodule

`default_nettype wire

// File: tb/tb_shiftreg_sipo_rx.sv
// ---------------------------------------------------------------------------
// tb_shiftreg_sipo_rx: directed bench for both bit orders of the SIPO receiver.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_shiftreg_sipo_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic       start = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out, out_l;
    logic       out_valid, overrun, parity_err;
    logic       out_valid_l, overrun_l, parity_err_l;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shiftreg_sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .start(start),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .parity_err(parity_err)
    );

    shiftreg_sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .start(start),
        .out(out_l), .out_valid(out_valid_l), .out_ready(out_ready),
        .overrun(overrun_l), .parity_err(parity_err_l)
    );

    // Called at a negedge; returns at the negedge after the bit is clocked in.
    task automatic drive_bit(input logic b, input logic st, input int gap);
        for (int g = 0; g < gap; g++) begin
            sin = ~b; sin_valid = 1'b0; start = 1'b0;
            @(negedge clk);
        end
        sin = b; sin_valid = 1'b1; start = st;
        @(negedge clk);
        sin_valid = 1'b0; start = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] w, input int gapmax, input logic rdy_last,
                              input logic bad_par, input logic hold_start);
        logic save;
        save = out_ready;
        for (int i = 7; i >= 0; i--) begin
`ifndef SHIFTREG_SIPO_PARITY_EN
            if (i == 0) out_ready = rdy_last;
`endif
            drive_bit(w[i], (i == 7) || hold_start, (i == 7) ? 0 : int'($urandom_range(0, gapmax)));
        end
`ifdef SHIFTREG_SIPO_PARITY_EN
        out_ready = rdy_last;
        drive_bit((^w) ^ bad_par, hold_start, int'($urandom_range(0, gapmax)));
`else
        if (bad_par) $display("note: parity corruption ignored in this build");
`endif
        out_ready = save;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (out !== 8'h00) begin n_err++; $display("FAIL reset_out: got %h want 00", out); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b want 0", parity_err); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_msb_first;
        logic [7:0] w;
        w = 8'hC5;
        out_ready = 1'b1;
        for (int i = 7; i >= 1; i--) drive_bit(w[i], i == 7, 0);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL msb_early_valid: got %b want 0", out_valid); end
        drive_bit(w[0], 1'b0, 0);
`ifdef SHIFTREG_SIPO_PARITY_EN
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL msb_pre_parity_valid: got %b want 0", out_valid); end
        drive_bit(1'b0, 1'b0, 0);
`endif
        n_vec++; if (out !== 8'hC5) begin n_err++; $display("FAIL msb_out: got %h want c5", out); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL msb_valid: got %b want 1", out_valid); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL msb_consume: got %b want 0", out_valid); end
        n_vec++; if (out !== 8'hC5) begin n_err++; $display("FAIL msb_hold_out: got %h want c5", out); end
    endtask

    task automatic test_lsb_first;
        out_ready = 1'b1;
        send_frame(8'hC5, 3, 1'b1, 1'b0, 1'b0);
        n_vec++; if (out_l !== 8'hA3) begin n_err++; $display("FAIL lsb_out: got %h want a3", out_l); end
        n_vec++; if (out_valid_l !== 1'b1) begin n_err++; $display("FAIL lsb_valid: got %b want 1", out_valid_l); end
        n_vec++; if (out !== 8'hC5) begin n_err++; $display("FAIL lsb_gap_msb_out: got %h want c5", out); end
        n_vec++; if (overrun_l !== 1'b0 || parity_err_l !== 1'b0) begin n_err++; $display("FAIL lsb_flags: got %b%b want 00", overrun_l, parity_err_l); end
        @(negedge clk);
    endtask

    task automatic test_overrun;
        out_ready = 1'b0;
        send_frame(8'h12, 0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (out !== 8'h12 || out_valid !== 1'b1) begin n_err++; $display("FAIL ovr_first: got %h/%b want 12/1", out, out_valid); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_first_flag: got %b want 0", overrun); end
        send_frame(8'h34, 0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
        n_vec++; if (out !== 8'h12 || out_valid !== 1'b1) begin n_err++; $display("FAIL ovr_keep: got %h/%b want 12/1", out, out_valid); end
        @(negedge clk);
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_width: got %b want 0", overrun); end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovr_drain: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_ready_at_commit;
        out_ready = 1'b0;
        send_frame(8'h12, 0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h34, 0, 1'b1, 1'b0, 1'b0);
        n_vec++; if (out !== 8'h34 || out_valid !== 1'b1) begin n_err++; $display("FAIL rac_out: got %h/%b want 34/1", out, out_valid); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rac_overrun: got %b want 0", overrun); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midframe;
        logic [7:0] w;
        w = 8'h5A;
        out_ready = 1'b0;
        send_frame(8'h3C, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 7; i >= 4; i--) drive_bit(w[i], i == 7, 0);
        rst = 1'b0;
        #1;
        n_vec++; if (out !== 8'h00 || out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_out: got %h/%b want 00/0", out, out_valid); end
        n_vec++; if (overrun !== 1'b0 || parity_err !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags: got %b%b want 00", overrun, parity_err); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_frame(8'h5A, 0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (out !== 8'h5A || out_valid !== 1'b1) begin n_err++; $display("FAIL mid_next: got %h/%b want 5a/1", out, out_valid); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        send_frame(8'hA5, 0, 1'b1, 1'b0, 1'b1);
        n_vec++; if (out !== 8'hA5 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first: got %h/%b want a5/1", out, out_valid); end
        send_frame(8'h3C, 0, 1'b1, 1'b0, 1'b0);
        n_vec++; if (out !== 8'h3C || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second: got %h/%b want 3c/1", out, out_valid); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_parity;
        out_ready = 1'b0;
        send_frame(8'h07, 0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (out !== 8'h07 || out_valid !== 1'b1) begin n_err++; $display("FAIL par_good: got %h/%b want 07/1", out, out_valid); end
        n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL par_good_flag: got %b want 0", parity_err); end
`ifdef SHIFTREG_SIPO_PARITY_EN
        send_frame(8'h07, 0, 1'b0, 1'b1, 1'b0);
        n_vec++; if (parity_err !== 1'b1) begin n_err++; $display("FAIL par_err_pulse: got %b want 1", parity_err); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL par_no_overrun: got %b want 0", overrun); end
        n_vec++; if (out !== 8'h07 || out_valid !== 1'b1) begin n_err++; $display("FAIL par_keep: got %h/%b want 07/1", out, out_valid); end
        @(negedge clk);
        n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL par_err_width: got %b want 0", parity_err); end
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_msb_first;
        test_lsb_first;
        test_overrun;
        test_ready_at_commit;
        test_reset_midframe;
        test_back_to_back;
        test_parity;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shiftreg_sipo_rx.md
# shiftreg_sipo_rx

Serial-in/parallel-out receiver that rebuilds a WIDTH-bit word from a bit-strobed serial stream and presents it on a one-deep ready/valid output buffer. It sits at the receive end of the team's serial link, opposite the parallel-load shift registers that drive words onto the line. Downstream parallel logic consumes words through the buffer. The buffer lets the next frame shift in while the previous word is still waiting.

## Interface
- WIDTH, 8: data bits per frame (≥2).
- MSB_FIRST, 1: 1 means the first received bit lands in out[WIDTH-1]; 0 means it lands in out[0].
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled only in cycles where this is 1.
- start  input  1  frame start qualifier; honoured only in IDLE together with sin_valid.
- out  output  WIDTH  received word (buffer contents).
- out_valid  output  1  buffer holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- overrun  output  1  one-cycle pulse when a completed word is dropped.
- parity_err  output  1  one-cycle pulse on parity mismatch (tied 0 without the macro).

## Operation
- FSM states:
  - IDLE: bit counter is 0.
  - SHIFT: accepting data bits.
  - PARITY: exists only with the macro.
- IDLE → SHIFT when start && sin_valid. That sin is data bit 0, and the counter becomes 1.
- In SHIFT, each sin_valid cycle shifts sin into the internal shift register and increments the counter. start is ignored.
- The cycle that accepts bit WIDTH-1 completes the word:
  - Without the macro, the FSM returns to IDLE.
  - With the macro, the FSM goes to PARITY.
- Completion commit to the buffer:
  - If the buffer is empty, or out_valid && out_ready in that same cycle, the word loads into out and out_valid=1.
  - Otherwise the new word is discarded, out/out_valid are unchanged, and overrun pulses.
- Consume: out_valid && out_ready with no simultaneous commit clears out_valid. out keeps its last value.
- Bit order:
  - MSB_FIRST=1: shift left, inserting sin at bit 0.
  - MSB_FIRST=0: shift right, inserting sin at bit WIDTH-1.
- Counter width is $clog2(WIDTH+1). The counter is never compared beyond WIDTH.
- Reset (rst=0 at any time, including mid-frame):
  - FSM goes to IDLE; counter and shift register clear to 0.
  - Outputs reset to out=0, out_valid=0, overrun=0, parity_err=0.
  - Any partial frame or buffered word is lost.

## Timing
- Latency: the last data bit (or parity bit) is accepted in cycle N. out/out_valid are visible from cycle N+1 (registered outputs).
- Gaps: any number of sin_valid=0 cycles may occur between bits, with no timeout.
- A back-to-back frame may start in the cycle immediately after completion.
- overrun and parity_err are registered and asserted for exactly the cycle after the offending completion.
- out_ready is combinationally observed only for the commit/consume decision. There is no combinational path from inputs to outputs.

## Configuration
- SHIFTREG_SIPO_PARITY_EN:
  - Defined: after WIDTH data bits, the FSM enters PARITY and the next sin_valid bit is an even-parity bit over the data.
  - On match, the word commits as above.
  - On mismatch, the word is discarded, parity_err pulses, and overrun is not raised.
  - The FSM returns to IDLE either way.
- Undefined: no PARITY state, frame length is WIDTH, and parity_err is constant 0.

## Structure
- Shared package shiftreg_pkg holds:
  - FSM state encodings (ST_IDLE, ST_SHIFT, ST_PARITY) as localparams/typedef.
  - Default WIDTH constant.
- One sub-module, sipo_out_buf: the one-deep ready/valid holding register. It has load/data inputs, out_ready, out, out_valid, and a drop pulse that drives overrun.
- The FSM, counter and shift register live in the top.

## Test plan
- WIDTH=8, MSB_FIRST=1, bits 1,1,0,0,0,1,0,1 on consecutive sin_valid cycles with start on the first, out_ready=1 → out=8'hC5, out_valid=1 exactly one cycle after the 8th bit.
- Same stream with MSB_FIRST=0 and random sin_valid gaps of 0–3 cycles → out=8'hA3.
- out_ready=0 throughout, frames 8'h12 then 8'h34 → out stays 8'h12, out_valid stays 1, overrun pulses once after the second frame.
- Same two frames, with out_ready=1 only in the cycle where the second frame completes → out=8'h34, no overrun.
- Reset driven low after 4 bits of a frame, then a full frame 8'h5A → all outputs 0 during reset, and the next output is 8'h5A with no stale bits.
- With SHIFTREG_SIPO_PARITY_EN, send 8'h07 with parity 1 → out=8'h07. Then send 8'h07 with parity 0 → parity_err pulse, out_valid unchanged.
